// File: rtl/hazard_scoreboard_pkg.sv
// Shared widths and tracking-entry layout for the hazard scoreboard and its lookups.
package hazard_scoreboard_pkg;

   localparam int HS_NREG     = 32;
   localparam int HS_NSTAGE   = 3;
   localparam int HS_LOAD_LAT = 2;
   localparam int HS_AW       = $clog2(HS_NREG);
   localparam int HS_FW       = $clog2(HS_NSTAGE);
   localparam int HS_CW       = 32;

   // One in-flight instruction; the source fields are only consulted in stage 0.
   typedef struct packed {
      logic             valid;
      logic             wr;
      logic [HS_AW-1:0] rd;
      logic             is_load;
      logic [HS_AW-1:0] fwd_rs_src;
      logic [HS_AW-1:0] fwd_rt_src;
   } hs_entry_t;

   localparam hs_entry_t HS_BUBBLE = '0;

endpackage

// File: rtl/hs_youngest_match.sv
// Priority search: lowest-index candidate stage whose destination equals src (r0 never matches).
module hs_youngest_match #(
   parameter int N  = 3,
   parameter int AW = 5,
   parameter int IW = 2
) (
   input  logic [N-1:0]         cand,
   input  logic [N-1:0][AW-1:0] rd,
   input  logic [AW-1:0]        src,
   output logic                 hit,
   output logic [IW-1:0]        idx
);

   // NOTE: every output gets a default before the search so no latch can be inferred.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int j = N - 1; j >= 0; j--) begin
         if (cand[j] && (rd[j] == src) && (src != '0)) begin
            hit = 1'b1;
            idx = IW'(j);
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: load-use stall, forwarding selects and a stall counter.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter  int NREG     = HS_NREG,
   parameter  int NSTAGE   = HS_NSTAGE,
   parameter  int LOAD_LAT = HS_LOAD_LAT,
   localparam int AW       = $clog2(NREG),
   localparam int FW       = $clog2(NSTAGE)
) (
   input  logic             hs_clk,
   input  logic             hs_rst,
   input  logic             hs_i_valid,
   input  logic [AW-1:0]    hs_i_rs,
   input  logic [AW-1:0]    hs_i_rt,
   input  logic             hs_i_use_rs,
   input  logic             hs_i_use_rt,
   input  logic             hs_i_wr,
   input  logic [AW-1:0]    hs_i_rd,
   input  logic             hs_i_is_load,
   input  logic             hs_i_flush,
   input  logic             hs_i_cnt_clr,
   output logic             hs_o_stall,
   output logic             hs_o_issue,
   output logic [FW-1:0]    hs_o_fwd_rs,
   output logic [FW-1:0]    hs_o_fwd_rt,
   output logic [HS_CW-1:0] hs_o_stall_cnt
);

   localparam logic [HS_CW-1:0] CNT_MAX = '1;

   hs_entry_t                  pipe [NSTAGE];
   hs_entry_t                  dec_entry;
   logic [NSTAGE-1:0]          cand_all, cand_fwd;
   logic [NSTAGE-1:0][AW-1:0]  rd_all;
   logic                       s_rs_hit, s_rt_hit, f_rs_hit, f_rt_hit;
   logic [FW-1:0]              s_rs_idx, s_rt_idx, f_rs_idx, f_rt_idx;
   logic                       rs_haz, rt_haz;

   always_comb begin
      cand_all = '0;
      rd_all   = '0;
      for (int j = 0; j < NSTAGE; j++) begin
         cand_all[j] = pipe[j].valid && pipe[j].wr;
         rd_all[j]   = pipe[j].rd;
      end
      // The stage-0 instruction is the consumer of forwarding, never its own producer.
      cand_fwd    = cand_all;
      cand_fwd[0] = 1'b0;
   end

   hs_youngest_match #(.N(NSTAGE), .AW(AW), .IW(FW)) u_stall_rs (
      .cand(cand_all), .rd(rd_all), .src(hs_i_rs), .hit(s_rs_hit), .idx(s_rs_idx));
   hs_youngest_match #(.N(NSTAGE), .AW(AW), .IW(FW)) u_stall_rt (
      .cand(cand_all), .rd(rd_all), .src(hs_i_rt), .hit(s_rt_hit), .idx(s_rt_idx));
   hs_youngest_match #(.N(NSTAGE), .AW(AW), .IW(FW)) u_fwd_rs (
      .cand(cand_fwd), .rd(rd_all), .src(pipe[0].fwd_rs_src), .hit(f_rs_hit), .idx(f_rs_idx));
   hs_youngest_match #(.N(NSTAGE), .AW(AW), .IW(FW)) u_fwd_rt (
      .cand(cand_fwd), .rd(rd_all), .src(pipe[0].fwd_rt_src), .hit(f_rt_hit), .idx(f_rt_idx));

   // A load producer stalls only while its data is still before the forwardable stage.
   assign rs_haz = hs_i_use_rs && s_rs_hit && pipe[s_rs_idx].is_load
                   && ((int'(s_rs_idx) + 1) < LOAD_LAT);
   assign rt_haz = hs_i_use_rt && s_rt_hit && pipe[s_rt_idx].is_load
                   && ((int'(s_rt_idx) + 1) < LOAD_LAT);

   assign hs_o_stall  = !hs_rst && hs_i_valid && !hs_i_flush && (rs_haz || rt_haz);
   assign hs_o_issue  = !hs_rst && hs_i_valid && !hs_i_flush && !hs_o_stall;
   assign hs_o_fwd_rs = (pipe[0].valid && f_rs_hit) ? f_rs_idx : '0;
   assign hs_o_fwd_rt = (pipe[0].valid && f_rt_hit) ? f_rt_idx : '0;

   always_comb begin
      dec_entry            = HS_BUBBLE;
      dec_entry.valid      = 1'b1;
      dec_entry.wr         = hs_i_wr;
      dec_entry.rd         = hs_i_rd;
      dec_entry.is_load    = hs_i_is_load;
      dec_entry.fwd_rs_src = hs_i_rs;
      dec_entry.fwd_rt_src = hs_i_rt;
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples the old value.
   always_ff @(posedge hs_clk or posedge hs_rst) begin
      if (hs_rst) begin
         for (int j = 0; j < NSTAGE; j++) pipe[j] <= HS_BUBBLE;
      end else begin
         pipe[0] <= hs_o_issue ? dec_entry : HS_BUBBLE;
         for (int j = 1; j < NSTAGE; j++) pipe[j] <= pipe[j-1];
      end
   end

   always_ff @(posedge hs_clk or posedge hs_rst) begin
      if (hs_rst)
         hs_o_stall_cnt <= '0;
      else if (hs_i_cnt_clr)
         hs_o_stall_cnt <= '0;
      else if (hs_o_stall && (hs_o_stall_cnt != CNT_MAX))
         hs_o_stall_cnt <= hs_o_stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus random decode traffic against an age-based model.
module tb_hazard_scoreboard;

   localparam int NREG     = 32;
   localparam int NSTAGE   = 3;
   localparam int LOAD_LAT = 2;

   logic        hs_clk = 1'b0;
   logic        hs_rst;
   logic        hs_i_valid, hs_i_use_rs, hs_i_use_rt, hs_i_wr, hs_i_is_load;
   logic        hs_i_flush, hs_i_cnt_clr;
   logic [4:0]  hs_i_rs, hs_i_rt, hs_i_rd;
   logic        hs_o_stall, hs_o_issue;
   logic [1:0]  hs_o_fwd_rs, hs_o_fwd_rt;
   logic [31:0] hs_o_stall_cnt;

   hazard_scoreboard #(.NREG(NREG), .NSTAGE(NSTAGE), .LOAD_LAT(LOAD_LAT)) dut (
      .hs_clk(hs_clk), .hs_rst(hs_rst), .hs_i_valid(hs_i_valid),
      .hs_i_rs(hs_i_rs), .hs_i_rt(hs_i_rt), .hs_i_use_rs(hs_i_use_rs), .hs_i_use_rt(hs_i_use_rt),
      .hs_i_wr(hs_i_wr), .hs_i_rd(hs_i_rd), .hs_i_is_load(hs_i_is_load),
      .hs_i_flush(hs_i_flush), .hs_i_cnt_clr(hs_i_cnt_clr),
      .hs_o_stall(hs_o_stall), .hs_o_issue(hs_o_issue),
      .hs_o_fwd_rs(hs_o_fwd_rs), .hs_o_fwd_rt(hs_o_fwd_rt), .hs_o_stall_cnt(hs_o_stall_cnt));

   always #5 hs_clk = ~hs_clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: hist[a] is the instruction that entered EX a cycles ago (a=1 is in EX now).
   typedef struct {
      bit v, wr, ld;
      int rd, rs, rt;
   } ins_t;

   ins_t     hist [1:NSTAGE];
   bit [31:0] m_cnt;
   bit        obs_stall, obs_issue;
   int        obs_frs, obs_frt;

   function automatic int youngest_age(input int s, input int lo);
      for (int a = lo; a <= NSTAGE; a++)
         if (hist[a].v && hist[a].wr && hist[a].rd == s && s != 0) return a;
      return 0;
   endfunction

   function automatic bit load_use(input int s);
      int a;
      a = youngest_age(s, 1);
      return (a != 0) && hist[a].ld && (a < LOAD_LAT);
   endfunction

   function automatic int fwd_sel(input int s);
      int a;
      if (!hist[1].v) return 0;
      a = youngest_age(s, 2);
      return (a == 0) ? 0 : a - 1;
   endfunction

   task automatic model_clear();
      for (int a = 1; a <= NSTAGE; a++) hist[a] = '{default: 0};
      m_cnt = '0;
   endtask

   // One decode cycle: drive, compare combinational outputs, clock, advance the model.
   task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit wr, input int rd, input bit ld, input bit fl, input bit clr);
      bit e_stall, e_issue;
      hs_i_valid = v;  hs_i_rs = 5'(rs);  hs_i_rt = 5'(rt);
      hs_i_use_rs = urs;  hs_i_use_rt = urt;  hs_i_wr = wr;  hs_i_rd = 5'(rd);
      hs_i_is_load = ld;  hs_i_flush = fl;  hs_i_cnt_clr = clr;
      #1;
      e_stall = v && !fl && ((urs && load_use(rs)) || (urt && load_use(rt)));
      e_issue = v && !fl && !e_stall;
      obs_stall = hs_o_stall;  obs_issue = hs_o_issue;
      obs_frs = int'(hs_o_fwd_rs);  obs_frt = int'(hs_o_fwd_rt);
      check("stall", 32'(hs_o_stall), 32'(e_stall));
      check("issue", 32'(hs_o_issue), 32'(e_issue));
      check("fwd_rs", 32'(hs_o_fwd_rs), 32'(fwd_sel(hist[1].rs)));
      check("fwd_rt", 32'(hs_o_fwd_rt), 32'(fwd_sel(hist[1].rt)));
      check("stall_cnt", hs_o_stall_cnt, m_cnt);
      @(posedge hs_clk);
      if (clr) m_cnt = '0;
      else if (e_stall && m_cnt != '1) m_cnt = m_cnt + 1;
      for (int a = NSTAGE; a > 1; a--) hist[a] = hist[a-1];
      if (e_issue) hist[1] = '{v: 1'b1, wr: wr, ld: ld, rd: rd, rs: rs, rt: rt};
      else         hist[1] = '{default: 0};
      @(negedge hs_clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Plain ALU/load helpers: rs/rt used, writes rd.
   task automatic alu(input int rs, input int rt, input int rd);
      step(1, rs, rt, 1, 1, 1, rd, 0, 0, 0);
   endtask

   initial begin
      bit [31:0] cnt_before;
      model_clear();
      hs_rst = 1'b1;
      hs_i_valid = 1'b1;  hs_i_rs = 5'd1;  hs_i_rt = 5'd2;  hs_i_use_rs = 1'b1;  hs_i_use_rt = 1'b1;
      hs_i_wr = 1'b1;  hs_i_rd = 5'd3;  hs_i_is_load = 1'b0;  hs_i_flush = 1'b0;  hs_i_cnt_clr = 1'b0;
      #1;
      check("rst_stall", 32'(hs_o_stall), 0);
      check("rst_issue", 32'(hs_o_issue), 0);
      check("rst_fwd_rs", 32'(hs_o_fwd_rs), 0);
      check("rst_cnt", hs_o_stall_cnt, 0);
      @(negedge hs_clk);
      hs_rst = 1'b0;

      // Load-use: one stall cycle, issue next, forwarded from stage 2.
      step(1, 1, 2, 1, 1, 1, 4, 1, 0, 0);
      step(1, 4, 0, 1, 1, 1, 10, 0, 0, 0);
      check("lu_stall", 32'(obs_stall), 1);
      check("lu_noissue", 32'(obs_issue), 0);
      step(1, 4, 0, 1, 1, 1, 10, 0, 0, 0);
      check("lu_stall_once", 32'(obs_stall), 0);
      check("lu_issue", 32'(obs_issue), 1);
      idle(1);
      check("lu_fwd2", 32'(obs_frs), 2);
      check("lu_cnt1", hs_o_stall_cnt, 1);
      idle(3);

      // ALU producer immediately followed by consumer.
      alu(1, 2, 3);
      alu(3, 0, 11);
      check("alu_nostall", 32'(obs_stall), 0);
      idle(1);
      check("alu_fwd1", 32'(obs_frs), 1);
      idle(3);

      // Distance 2 forwards from stage 2, distance 3 reads the register file.
      alu(1, 2, 6);  alu(1, 2, 7);  alu(0, 6, 12);  idle(1);
      check("dist2_fwd", 32'(obs_frt), 2);
      idle(3);
      alu(1, 2, 6);  alu(1, 2, 7);  alu(1, 2, 8);  alu(6, 0, 12);  idle(1);
      check("dist3_fwd", 32'(obs_frs), 0);
      idle(3);

      // Load to r0 never creates a hazard.
      step(1, 1, 2, 1, 1, 1, 0, 1, 0, 0);
      alu(0, 0, 13);
      check("r0_nostall", 32'(obs_stall), 0);
      idle(1);
      check("r0_fwd", 32'(obs_frs), 0);
      idle(3);

      // Two writes to r5: the younger one wins.
      alu(1, 2, 5);  alu(1, 2, 5);  alu(5, 5, 14);  idle(1);
      check("young_fwd_rs", 32'(obs_frs), 1);
      check("young_fwd_rt", 32'(obs_frt), 1);
      idle(3);

      // Flush beats a load-use stall and leaves the counter alone.
      cnt_before = hs_o_stall_cnt;
      step(1, 1, 2, 1, 1, 1, 8, 1, 0, 0);
      step(1, 8, 0, 1, 0, 1, 15, 0, 1, 0);
      check("fl_stall", 32'(obs_stall), 0);
      check("fl_issue", 32'(obs_issue), 0);
      check("fl_cnt", hs_o_stall_cnt, cnt_before);
      idle(3);

      // Clear wins over a same-cycle increment.
      step(1, 1, 2, 1, 1, 1, 9, 1, 0, 0);
      step(1, 0, 9, 0, 1, 1, 15, 0, 0, 1);
      check("clr_stall", 32'(obs_stall), 1);
      check("clr_cnt", hs_o_stall_cnt, 0);
      idle(3);

      // No valid instruction: no stall even with a pending load match.
      step(1, 1, 2, 1, 1, 1, 9, 1, 0, 0);
      step(0, 9, 9, 1, 1, 1, 15, 0, 0, 0);
      check("inv_stall", 32'(obs_stall), 0);
      idle(3);

      // Reset in the middle of a load-use stall.
      step(1, 1, 2, 1, 1, 1, 4, 1, 0, 0);
      hs_i_valid = 1'b1;  hs_i_rs = 5'd4;  hs_i_use_rs = 1'b1;  hs_i_use_rt = 1'b0;
      hs_i_wr = 1'b1;  hs_i_rd = 5'd16;  hs_i_is_load = 1'b0;  hs_i_flush = 1'b0;  hs_i_cnt_clr = 1'b0;
      #1;
      check("mid_stall", 32'(hs_o_stall), 1);
      hs_rst = 1'b1;
      #1;
      check("mid_rst_stall", 32'(hs_o_stall), 0);
      check("mid_rst_issue", 32'(hs_o_issue), 0);
      check("mid_rst_fwd", 32'(hs_o_fwd_rs), 0);
      check("mid_rst_cnt", hs_o_stall_cnt, 0);
      @(negedge hs_clk);
      hs_rst = 1'b0;
      model_clear();
      alu(17, 18, 19);
      check("post_rst_issue", 32'(obs_issue), 1);
      idle(1);
      check("post_rst_fwd", 32'(obs_frs), 0);

      // Random decode traffic over a small register window to provoke matches.
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) != 0, int'($urandom % 6), int'($urandom % 6),
              ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
              int'($urandom % 6), ($urandom % 3) == 0, ($urandom % 8) == 0,
              ($urandom % 32) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
